// File: rtl/rec_play_ctrl_pkg.sv
// rec_pkg: shared state encoding and default widths for the
// sound recorder capture/playback datapath.
package rec_pkg;
    localparam int ADDR_W_DEF = 18;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_PLAY   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;
endpackage

// File: rtl/rec_play_ctrl_mem_port_seq.sv
// mem_port_seq: single-outstanding memory request/ack sequencer;
// request fields are captured on start and held until the ack.
module mem_port_seq
    import rec_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              ack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              req_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o
);
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (req_q) begin
            if (ack_i) req_q <= 1'b0;
        end else if (start_i) begin
            req_q   <= 1'b1;
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    assign busy_o  = req_q;
    assign done_o  = req_q & ack_i;
    assign req_o   = req_q;
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
endmodule

// File: rtl/rec_play_ctrl.sv
// rec_play_ctrl: record/playback sequencer owning the sample memory port.
// Define LOOP_PLAY_EN to make playback wrap to address 0 until cmd_stop.
module rec_play_ctrl
    import rec_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_record,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    output logic              adc_enable,
    input  logic              adc_valid,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              dac_req,
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        state_o,
    // one extra bit so a completely full memory reports 2^ADDR_W
    output logic [ADDR_W:0]   rec_len,
    output logic              overrun
);
`ifdef LOOP_PLAY_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W:0]   ONE_L = 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              ovr_q, ovr_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] pbuf_q, pbuf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dval_q, dval_d;
    logic              aen_q;

    logic              start, st_we, busy, done, used_adc;
    logic [DATA_W-1:0] st_wdata;
    logic              wr_done, rd_done, wr_full, rd_last, adc_take;

    mem_port_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_seq (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start),
        .we_i    (st_we),
        .addr_i  (cnt_q),
        .wdata_i (st_wdata),
        .ack_i   (mem_ack),
        .busy_o  (busy),
        .done_o  (done),
        .req_o   (mem_req),
        .we_o    (mem_we),
        .addr_o  (mem_addr),
        .wdata_o (mem_wdata)
    );

    always_comb begin
        wr_done  = done & mem_we;
        rd_done  = done & ~mem_we;
        wr_full  = wr_done & (&mem_addr);
        rd_last  = rd_done & ({1'b0, cnt_q} == len_q - ONE_L);
        adc_take = (state_q == ST_RECORD) & ~cmd_stop
                 & adc_valid & ~wr_full;

        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ovr_d    = ovr_q;
        pend_d   = pend_q;
        pbuf_d   = pbuf_q;
        dout_d   = dout_q;
        dval_d   = 1'b0;
        start    = 1'b0;
        st_we    = 1'b0;
        st_wdata = '0;
        used_adc = 1'b0;

        // a waiting sample always goes to the port before a fresh one
        if ((state_q == ST_RECORD || state_q == ST_DRAIN) && !busy) begin
            if (pend_q) begin
                start    = 1'b1;
                st_we    = 1'b1;
                st_wdata = pbuf_q;
                pend_d   = 1'b0;
            end else if (adc_take) begin
                start    = 1'b1;
                st_we    = 1'b1;
                st_wdata = adc_data;
                used_adc = 1'b1;
            end
        end
        if (adc_take && !used_adc) begin
            if (pend_d) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
                pbuf_d = adc_data;
            end
        end
        if (wr_done) begin
            len_d = {1'b0, cnt_q} + ONE_L;
            if (!wr_full) cnt_d = cnt_q + ONE_A;
        end
        if (wr_full) begin
            if (pend_d) ovr_d = 1'b1;
            pend_d = 1'b0;
        end

        if (state_q == ST_PLAY && !cmd_stop && dac_req) begin
            if (!busy) start = 1'b1;
            else       ovr_d = 1'b1;
        end
        if (rd_done) begin
            cnt_d = (LOOP && rd_last) ? '0 : cnt_q + ONE_A;
            if (state_q == ST_PLAY) begin
                dout_d = mem_rdata;
                dval_d = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!cmd_stop && cmd_record) begin
                    state_d = ST_RECORD;
                    cnt_d   = '0;
                    len_d   = '0;
                    ovr_d   = 1'b0;
                    pend_d  = 1'b0;
                end else if (!cmd_stop && cmd_play && len_q != '0) begin
                    state_d = ST_PLAY;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                end
            end
            ST_RECORD: if (cmd_stop || wr_full) state_d = ST_DRAIN;
            ST_PLAY: begin
                if (cmd_stop)              state_d = ST_DRAIN;
                else if (rd_last && !LOOP) state_d = ST_IDLE;
            end
            ST_DRAIN: if (!pend_q && (!busy || done)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ovr_q   <= 1'b0;
            pend_q  <= 1'b0;
            pbuf_q  <= '0;
            dout_q  <= '0;
            dval_q  <= 1'b0;
            aen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ovr_q   <= ovr_d;
            pend_q  <= pend_d;
            pbuf_q  <= pbuf_d;
            dout_q  <= dout_d;
            dval_q  <= dval_d;
            aen_q   <= (state_d == ST_RECORD);
        end
    end

    assign adc_enable = aen_q;
    assign dac_data   = dout_q;
    assign dac_valid  = dval_q;
    assign state_o    = state_q;
    assign rec_len    = len_q;
    assign overrun    = ovr_q;
endmodule

// File: tb/tb_rec_play_ctrl.sv
// tb_rec_play_ctrl: randomized self-checking bench with a behavioural
// memory responder and a sample-list model of record/playback.
`timescale 1ns/1ps
module tb_rec_play_ctrl;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_record = 1'b0, cmd_play = 1'b0, cmd_stop = 1'b0;
    logic adc_valid = 1'b0, dac_req = 1'b0, mem_ack = 1'b0;
    logic [DW-1:0] adc_data = '0, mem_rdata = '0;
    logic adc_enable, dac_valid, mem_req, mem_we, overrun;
    logic [DW-1:0] dac_data, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [1:0] state_o;
    logic [AW:0] rec_len;

    int checks = 0, errors = 0;
    int lat_lo = 1, lat_hi = 1;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    logic [DW-1:0] model[$];

    always #5 clk = ~clk;

    rec_play_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_record(cmd_record), .cmd_play(cmd_play), .cmd_stop(cmd_stop),
        .adc_enable(adc_enable), .adc_valid(adc_valid), .adc_data(adc_data),
        .dac_req(dac_req), .dac_data(dac_data), .dac_valid(dac_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .state_o(state_o), .rec_len(rec_len), .overrun(overrun)
    );

    // memory responder: random latency, checks request stability
    initial begin : responder
        int wcnt;
        bit busy;
        logic [AW+DW:0] saved;
        wcnt = 0;
        busy = 1'b0;
        saved = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                busy = 1'b0;
            end else if (!rst_n || mem_req !== 1'b1) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = int'($urandom_range(lat_hi, lat_lo));
                    saved = {mem_we, mem_addr, mem_wdata};
                end else begin
                    checks++;
                    if (saved !== {mem_we, mem_addr, mem_wdata}) begin
                        errors++;
                        $display("FAIL mem_stable: got %h want %h",
                                 {mem_we, mem_addr, mem_wdata}, saved);
                    end
                end
                wcnt--;
                if (wcnt <= 0) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr] = mem_wdata;
                        wq_addr.push_back(mem_addr);
                        wq_data.push_back(mem_wdata);
                    end else begin
                        mem_rdata = mem[mem_addr];
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk); #2;
    endtask

    task automatic pulse_rec;
        cmd_record = 1'b1; tick; cmd_record = 1'b0;
    endtask

    task automatic pulse_play;
        cmd_play = 1'b1; tick; cmd_play = 1'b0;
    endtask

    task automatic pulse_stop;
        cmd_stop = 1'b1; tick; cmd_stop = 1'b0;
    endtask

    task automatic adc_pulse(input logic [DW-1:0] v);
        adc_valid = 1'b1; adc_data = v; tick; adc_valid = 1'b0;
    endtask

    task automatic drive_samples(input int n, input bit rnd, input int gap);
        logic [DW-1:0] v;
        for (int i = 0; i < n; i++) begin
            v = rnd ? DW'($urandom) : DW'(i + 1);
            model.push_back(v);
            adc_pulse(v);
            repeat (gap) tick;
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (state_o === 2'd0) ok = 1'b1;
            else tick;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: state %0d, want 0", name, state_o);
        end
    endtask

    task automatic test_reset;
        lat_lo = 6; lat_hi = 6;
        rst_n = 1'b0; tick; tick; rst_n = 1'b1; tick;
        pulse_rec;
        adc_pulse(16'h1234);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_req: got %b want 1", mem_req);
        end
        rst_n = 1'b0; tick;
        checks++;
        if ({adc_enable, dac_valid, dac_data, mem_req, mem_we, mem_addr,
             mem_wdata, state_o, rec_len, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: st=%0d len=%0d req=%b en=%b",
                     state_o, rec_len, mem_req, adc_enable);
        end
        rst_n = 1'b1; tick; tick;
        wq_addr.delete(); wq_data.delete();
    endtask

    task automatic test_cmd_prio;
        bit req_seen;
        cmd_stop = 1'b1; cmd_record = 1'b1; tick;
        cmd_stop = 1'b0; cmd_record = 1'b0;
        checks++;
        if (state_o !== 2'd0 || adc_enable !== 1'b0) begin
            errors++;
            $display("FAIL stop_rec_prio: state %0d en %b, want 0 0",
                     state_o, adc_enable);
        end
        pulse_play;
        req_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (mem_req !== 1'b0 || state_o !== 2'd0) req_seen = 1'b1;
            tick;
        end
        checks++;
        if (req_seen) begin
            errors++;
            $display("FAIL play_empty: activity seen, want idle/no mem_req");
        end
    endtask

    task automatic test_record_plan;
        lat_lo = 3; lat_hi = 3;
        model.delete(); wq_addr.delete(); wq_data.delete();
        pulse_rec;
        checks++;
        if (state_o !== 2'd1 || adc_enable !== 1'b1) begin
            errors++;
            $display("FAIL rec_start: state %0d en %b, want 1 1",
                     state_o, adc_enable);
        end
        drive_samples(5, 1'b0, 8);
        pulse_stop;
        checks++;
        if (state_o !== 2'd3 || adc_enable !== 1'b0) begin
            errors++;
            $display("FAIL rec_drain: state %0d en %b, want 3 0",
                     state_o, adc_enable);
        end
        tick;
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL rec_idle: state %0d want 0", state_o);
        end
        checks++;
        if (wq_addr.size() != 5 || rec_len !== 4'd5 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rec_summary: writes %0d len %0d ovr %b, want 5 5 0",
                     wq_addr.size(), rec_len, overrun);
        end
        for (int i = 0; i < wq_addr.size() && i < 5; i++) begin
            checks++;
            if (wq_addr[i] !== AW'(i) || wq_data[i] !== model[i]) begin
                errors++;
                $display("FAIL rec_write%0d: got %0d/%h want %0d/%h",
                         i, wq_addr[i], wq_data[i], i, model[i]);
            end
        end
    endtask

    task automatic test_play;
        bit found;
        lat_lo = 1; lat_hi = 4;
        pulse_play;
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL play_start: state %0d want 2", state_o);
        end
        for (int i = 0; i < model.size(); i++) begin
            repeat ($urandom_range(3, 0)) tick;
            dac_req = 1'b1; tick; dac_req = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 30 && !found; k++) begin
                tick;
                if (dac_valid === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found || dac_data !== model[i]) begin
                errors++;
                $display("FAIL play_data%0d: got %h valid %b want %h",
                         i, dac_data, found, model[i]);
            end
        end
`ifdef LOOP_PLAY_EN
        dac_req = 1'b1; tick; dac_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            tick;
            if (dac_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || dac_data !== model[0] || state_o !== 2'd2) begin
            errors++;
            $display("FAIL play_loop: got %h st %0d want %h st 2",
                     dac_data, state_o, model[0]);
        end
        pulse_stop;
        wait_idle("play_loop_stop");
`else
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL play_end: state %0d want 0", state_o);
        end
`endif
        checks++;
        if (rec_len !== (AW + 1)'(model.size()) || overrun !== 1'b0) begin
            errors++;
            $display("FAIL play_keep: len %0d ovr %b want %0d 0",
                     rec_len, overrun, model.size());
        end
    endtask

    task automatic test_overrun;
        logic [DW-1:0] a, b, c;
        lat_lo = 6; lat_hi = 6;
        wq_addr.delete(); wq_data.delete();
        a = DW'($urandom); b = DW'($urandom); c = ~b;
        pulse_rec;
        adc_pulse(a);
        tick;
        adc_pulse(b);
        tick;
        adc_pulse(c);
        repeat (25) tick;
        pulse_stop;
        wait_idle("ovr_idle");
        checks++;
        if (overrun !== 1'b1 || rec_len !== 4'd2) begin
            errors++;
            $display("FAIL ovr_flag: ovr %b len %0d want 1 2", overrun, rec_len);
        end
        checks++;
        if (wq_data.size() != 2 || wq_data[0] !== a || wq_data[1] !== b
            || wq_addr[1] !== AW'(1)) begin
            errors++;
            $display("FAIL ovr_writes: n %0d want 2 (%h,%h), dropped %h",
                     wq_data.size(), a, b, c);
        end
        pulse_rec;
        checks++;
        if (overrun !== 1'b0 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL ovr_clear: ovr %b st %0d want 0 1", overrun, state_o);
        end
        pulse_stop;
        wait_idle("ovr_clear_idle");
    endtask

    task automatic test_random;
        int n;
        lat_lo = 1; lat_hi = 4;
        model.delete(); wq_addr.delete(); wq_data.delete();
        n = int'($urandom_range(7, 2));
        pulse_rec;
        drive_samples(n, 1'b1, int'($urandom_range(10, 7)));
        pulse_stop;
        wait_idle("rand_idle");
        checks++;
        if (wq_data.size() != n || rec_len !== (AW + 1)'(n)) begin
            errors++;
            $display("FAIL rand_count: writes %0d len %0d want %0d",
                     wq_data.size(), rec_len, n);
        end
        for (int i = 0; i < wq_data.size() && i < n; i++) begin
            checks++;
            if (wq_addr[i] !== AW'(i) || wq_data[i] !== model[i]) begin
                errors++;
                $display("FAIL rand_write%0d: got %0d/%h want %0d/%h",
                         i, wq_addr[i], wq_data[i], i, model[i]);
            end
        end
        test_play;
    endtask

    task automatic test_full;
        lat_lo = 1; lat_hi = 2;
        model.delete(); wq_addr.delete(); wq_data.delete();
        pulse_rec;
        drive_samples(10, 1'b1, 6);
        repeat (5) tick;
        checks++;
        if (state_o !== 2'd0 || adc_enable !== 1'b0 || rec_len !== 4'd8
            || wq_data.size() != DEPTH) begin
            errors++;
            $display("FAIL full_end: st %0d en %b len %0d writes %0d",
                     state_o, adc_enable, rec_len, wq_data.size());
        end
        for (int i = 0; i < wq_data.size() && i < DEPTH; i++) begin
            checks++;
            if (wq_addr[i] !== AW'(i) || wq_data[i] !== model[i]) begin
                errors++;
                $display("FAIL full_write%0d: got %0d/%h want %0d/%h",
                         i, wq_addr[i], wq_data[i], i, model[i]);
            end
        end
    endtask

    task automatic test_stop_play;
        bit seen;
        lat_lo = 4; lat_hi = 4;
        pulse_play;
        dac_req = 1'b1; tick; dac_req = 1'b0;
        pulse_stop;
        checks++;
        if (state_o !== 2'd3) begin
            errors++;
            $display("FAIL stop_play_drain: state %0d want 3", state_o);
        end
        seen = 1'b0;
        for (int k = 0; k < 20 && state_o !== 2'd0; k++) begin
            if (dac_valid === 1'b1) seen = 1'b1;
            tick;
        end
        if (dac_valid === 1'b1) seen = 1'b1;
        checks++;
        if (seen || state_o !== 2'd0 || rec_len !== 4'd8) begin
            errors++;
            $display("FAIL stop_play: valid %b st %0d len %0d want 0 0 8",
                     seen, state_o, rec_len);
        end
    endtask

    initial begin
        test_reset;
        test_cmd_prio;
        test_record_plan;
        test_play;
        test_overrun;
        test_random;
        test_full;
        test_stop_play;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
